// File: rtl/alu_issue_if.sv
// alu_issue_if: decode-to-issue and issue-to-ALU handshake bundle
interface alu_issue_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic [6:0]               funct7;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [DATA_WIDTH-1:0]    imm;
    logic                     out_valid;
    logic                     out_ready;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic                     illegal;
    logic [15:0]              issue_count;

    modport master (
        output flush, in_valid, opcode, funct3, funct7, rs1_data, rs2_data, imm, out_ready,
        input  in_ready, out_valid, Operation, SrcA, SrcB, illegal, issue_count
    );

    modport slave (
        input  flush, in_valid, opcode, funct3, funct7, rs1_data, rs2_data, imm, out_ready,
        output in_ready, out_valid, Operation, SrcA, SrcB, illegal, issue_count
    );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: decodes RV fields into ALU op/operands, issued through an ID/EX register with a one-entry skid buffer
module alu_issue #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_issue_if.slave bus
);
    typedef struct packed {
        logic [OPCODE_LENGTH-1:0] op;
        logic [DATA_WIDTH-1:0]    a;
        logic [DATA_WIDTH-1:0]    b;
        logic                     ill;
    } entry_t;

    entry_t      r_m, r_s, w_new;
    logic        r_m_valid, r_s_valid;
    logic [15:0] r_count;
    logic        w_alt, w_f7ok, w_r_ok, w_i_ok, w_consume, w_accept;
    logic [3:0]  w_alu_op, w_br_op;

    // funct7=0100000 selects sub/sra and is only meaningful for funct3 000/101
    always_comb begin
        w_alt  = bus.funct7 == 7'b0100000;
        w_f7ok = bus.funct7 == 7'b0000000 || (w_alt && (bus.funct3 == 3'b000 || bus.funct3 == 3'b101));
        w_r_ok = bus.funct3 != 3'b011 && w_f7ok;
        w_i_ok = bus.funct3 != 3'b011 && ((bus.funct3 == 3'b001 || bus.funct3 == 3'b101) ? w_f7ok : 1'b1);
        case (bus.funct3)
            3'b000:  w_alu_op = (w_alt && bus.opcode == 7'b0110011) ? 4'b0001 : 4'b0000;
            3'b001:  w_alu_op = 4'b1000;
            3'b010:  w_alu_op = 4'b0101;
            3'b100:  w_alu_op = 4'b0010;
            3'b101:  w_alu_op = w_alt ? 4'b0110 : 4'b0111;
            3'b110:  w_alu_op = 4'b0011;
            default: w_alu_op = 4'b0100;
        endcase
        case (bus.funct3)
            3'b000:  w_br_op = 4'b1101;
            3'b001:  w_br_op = 4'b1010;
            3'b100:  w_br_op = 4'b1011;
            3'b101:  w_br_op = 4'b1100;
            default: w_br_op = 4'b1111;
        endcase
        w_new = '{op: '0, a: '0, b: '0, ill: 1'b1};
        case (bus.opcode)
            7'b0110011: if (w_r_ok) w_new = '{op: OPCODE_LENGTH'(w_alu_op), a: bus.rs1_data, b: bus.rs2_data, ill: 1'b0};
            7'b0010011: if (w_i_ok) w_new = '{op: OPCODE_LENGTH'(w_alu_op), a: bus.rs1_data, b: bus.imm, ill: 1'b0};
            7'b0000011,
            7'b0100011: w_new = '{op: '0, a: bus.rs1_data, b: bus.imm, ill: 1'b0};
            7'b1100011: if (w_br_op != 4'b1111) w_new = '{op: OPCODE_LENGTH'(w_br_op), a: bus.rs1_data, b: bus.rs2_data, ill: 1'b0};
            7'b0110111: w_new = '{op: '0, a: '0, b: bus.imm, ill: 1'b0};
            default:    w_new = '{op: '0, a: '0, b: '0, ill: 1'b1};
        endcase
    end

    assign w_consume = r_m_valid && bus.out_ready;
    assign w_accept  = bus.in_valid && !r_s_valid;

    // flush is checked before any load so it overrides accept and consume; counting is independent
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_m       <= '0;
            r_s       <= '0;
            r_count   <= '0;
        end else begin
            if (w_consume) r_count <= r_count + 16'd1;
            if (bus.flush) begin
                r_m_valid <= 1'b0;
                r_s_valid <= 1'b0;
            end else if (r_s_valid) begin
                if (w_consume) begin
                    r_m       <= r_s;
                    r_s_valid <= 1'b0;
                end
            end else if (w_accept && (!r_m_valid || w_consume)) begin
                r_m       <= w_new;
                r_m_valid <= 1'b1;
            end else if (w_accept) begin
                r_s       <= w_new;
                r_s_valid <= 1'b1;
            end else if (w_consume) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = !r_s_valid;
    assign bus.out_valid   = r_m_valid;
    assign bus.Operation   = r_m.op;
    assign bus.SrcA        = r_m.a;
    assign bus.SrcB        = r_m.b;
    assign bus.illegal     = r_m.ill;
    assign bus.issue_count = r_count;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench for the alu_issue decode/issue stage
module tb_alu_issue;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    alu_issue_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();
    alu_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        logic [3:0]  eop;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        eill;
    } vec_t;

    vec_t tbl [10];

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.imm      = im;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++; if ({bus.out_valid, bus.in_ready, bus.illegal} !== 3'b010) begin n_err++; $display("FAIL reset_flags: got %b expected 010", {bus.out_valid, bus.in_ready, bus.illegal}); end
        n_vec++; if ({bus.Operation, bus.SrcA, bus.SrcB} !== 68'd0) begin n_err++; $display("FAIL reset_payload: got %h expected 0", {bus.Operation, bus.SrcA, bus.SrcB}); end
        n_vec++; if (bus.issue_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", bus.issue_count); end
    endtask

    task automatic test_rtype_sub;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive(7'h33, 3'b000, 7'h20, 32'd5, 32'd3, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_vec++; if ({bus.out_valid, bus.illegal} !== 2'b10) begin n_err++; $display("FAIL sub_valid: got %b expected 10", {bus.out_valid, bus.illegal}); end
        n_vec++; if (bus.Operation !== 4'b0001) begin n_err++; $display("FAIL sub_op: got %b expected 0001", bus.Operation); end
        n_vec++; if ({bus.SrcA, bus.SrcB} !== {32'd5, 32'd3}) begin n_err++; $display("FAIL sub_src: got %h/%h expected 5/3", bus.SrcA, bus.SrcB); end
        @(negedge clk);
        n_vec++; if (bus.issue_count !== 16'd1) begin n_err++; $display("FAIL sub_count: got %0d expected 1", bus.issue_count); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL sub_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back;
        bus.out_ready = 1'b0;
        drive(7'h13, 3'b101, 7'h20, 32'h80, 32'd0, 32'd4);
        @(negedge clk);
        n_vec++; if ({bus.in_ready, bus.out_valid, bus.Operation} !== 6'b110110) begin n_err++; $display("FAIL b2b_first: got %b expected 110110", {bus.in_ready, bus.out_valid, bus.Operation}); end
        drive(7'h63, 3'b000, 7'h00, 32'd7, 32'd7, 32'd0);
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_skid_full: got %b expected 0", bus.in_ready); end
        n_vec++; if ({bus.Operation, bus.SrcA, bus.SrcB} !== {4'b0110, 32'h80, 32'd4}) begin n_err++; $display("FAIL b2b_hold: got %b/%h/%h expected 0110/80/4", bus.Operation, bus.SrcA, bus.SrcB); end
        drive(7'h03, 3'b010, 7'h00, 32'd100, 32'd0, 32'hFFFF_FFF8);
        @(negedge clk);
        n_vec++; if ({bus.in_ready, bus.out_valid, bus.Operation} !== 6'b010110) begin n_err++; $display("FAIL b2b_stall: got %b expected 010110", {bus.in_ready, bus.out_valid, bus.Operation}); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if ({bus.in_ready, bus.Operation, bus.SrcA, bus.SrcB} !== {1'b1, 4'b1101, 32'd7, 32'd7}) begin n_err++; $display("FAIL b2b_beq: got %b/%b/%h/%h expected 1/1101/7/7", bus.in_ready, bus.Operation, bus.SrcA, bus.SrcB); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_vec++; if ({bus.Operation, bus.SrcA, bus.SrcB, bus.illegal} !== {4'b0000, 32'd100, 32'hFFFF_FFF8, 1'b0}) begin n_err++; $display("FAIL b2b_lw: got %b/%h/%h/%b expected 0000/64/fffffff8/0", bus.Operation, bus.SrcA, bus.SrcB, bus.illegal); end
        @(negedge clk);
        n_vec++; if ({bus.out_valid, bus.issue_count} !== {1'b0, 16'd4}) begin n_err++; $display("FAIL b2b_count: got %b/%0d expected 0/4", bus.out_valid, bus.issue_count); end
    endtask

    task automatic test_illegal;
        tbl[0] = '{7'h7F, 3'd0, 7'h00, 32'd11,   32'd22, 32'd33,        4'b0000, 32'd0,     32'd0,         1'b1};
        tbl[1] = '{7'h33, 3'd3, 7'h00, 32'd9,    32'd9,  32'd0,         4'b0000, 32'd0,     32'd0,         1'b1};
        tbl[2] = '{7'h63, 3'd2, 7'h00, 32'd1,    32'd2,  32'd0,         4'b0000, 32'd0,     32'd0,         1'b1};
        tbl[3] = '{7'h33, 3'd4, 7'h20, 32'd5,    32'd6,  32'd0,         4'b0000, 32'd0,     32'd0,         1'b1};
        tbl[4] = '{7'h13, 3'd0, 7'h7F, 32'd10,   32'd0,  32'hFFFF_FFFF, 4'b0000, 32'd10,    32'hFFFF_FFFF, 1'b0};
        tbl[5] = '{7'h13, 3'd1, 7'h20, 32'd3,    32'd0,  32'd2,         4'b0000, 32'd0,     32'd0,         1'b1};
        tbl[6] = '{7'h23, 3'd2, 7'h00, 32'h1000, 32'd9,  32'h10,        4'b0000, 32'h1000,  32'h10,        1'b0};
        tbl[7] = '{7'h63, 3'd5, 7'h00, 32'd3,    32'd4,  32'd0,         4'b1100, 32'd3,     32'd4,         1'b0};
        tbl[8] = '{7'h33, 3'd2, 7'h00, 32'd1,    32'd2,  32'd0,         4'b0101, 32'd1,     32'd2,         1'b0};
        tbl[9] = '{7'h13, 3'd7, 7'h7F, 32'hF0,   32'd0,  32'hFFFF_FFFF, 4'b0100, 32'hF0,    32'hFFFF_FFFF, 1'b0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].a, tbl[i].b, tbl[i].im);
            @(negedge clk);
            n_vec++;
            if ({bus.out_valid, bus.Operation, bus.SrcA, bus.SrcB, bus.illegal} !== {1'b1, tbl[i].eop, tbl[i].ea, tbl[i].eb, tbl[i].eill}) begin
                n_err++;
                $display("FAIL decode[%0d]: got v=%b op=%b a=%h b=%h ill=%b expected v=1 op=%b a=%h b=%h ill=%b", i,
                         bus.out_valid, bus.Operation, bus.SrcA, bus.SrcB, bus.illegal, tbl[i].eop, tbl[i].ea, tbl[i].eb, tbl[i].eill);
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.issue_count !== 16'd14) begin n_err++; $display("FAIL decode_count: got %0d expected 14", bus.issue_count); end
    endtask

    task automatic test_flush;
        bus.out_ready = 1'b0;
        drive(7'h33, 3'b000, 7'h00, 32'd1, 32'd2, 32'd0);
        @(negedge clk);
        drive(7'h33, 3'b111, 7'h00, 32'd3, 32'd4, 32'd0);
        @(negedge clk);
        n_vec++; if ({bus.in_ready, bus.out_valid, bus.SrcA, bus.SrcB} !== {2'b01, 32'd1, 32'd2}) begin n_err++; $display("FAIL flush_full: got %b%b/%h/%h expected 01/1/2", bus.in_ready, bus.out_valid, bus.SrcA, bus.SrcB); end
        drive(7'h33, 3'b110, 7'h00, 32'hAA, 32'h55, 32'd0);
        bus.flush = 1'b1;
        @(negedge clk);
        n_vec++; if ({bus.out_valid, bus.in_ready, bus.issue_count} !== {2'b01, 16'd14}) begin n_err++; $display("FAIL flush_clear: got %b%b/%0d expected 01/14", bus.out_valid, bus.in_ready, bus.issue_count); end
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if ({bus.out_valid, bus.issue_count} !== {1'b0, 16'd14}) begin n_err++; $display("FAIL flush_dropped: got %b/%0d expected 0/14", bus.out_valid, bus.issue_count); end
        drive(7'h33, 3'b000, 7'h20, 32'd8, 32'd1, 32'd0);
        @(negedge clk);
        n_vec++; if ({bus.out_valid, bus.Operation} !== 5'b10001) begin n_err++; $display("FAIL flush_refill: got %b expected 10001", {bus.out_valid, bus.Operation}); end
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        n_vec++; if ({bus.out_valid, bus.issue_count} !== {1'b0, 16'd15}) begin n_err++; $display("FAIL flush_consume_count: got %b/%0d expected 0/15", bus.out_valid, bus.issue_count); end
    endtask

    task automatic test_wrap_lui;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_vec++; if (bus.issue_count !== 16'd0) begin n_err++; $display("FAIL wrap_reset: got %0d expected 0", bus.issue_count); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            if (i == 65535) drive(7'h37, 3'd0, 7'h09, 32'hDEAD, 32'hBEEF, 32'h1234_5000);
            else drive(7'h33, 3'd0, 7'h00, i, 32'd1, 32'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        n_vec++; if ({bus.Operation, bus.SrcA, bus.SrcB, bus.illegal} !== {4'b0000, 32'd0, 32'h1234_5000, 1'b0}) begin n_err++; $display("FAIL lui: got %b/%h/%h/%b expected 0000/0/12345000/0", bus.Operation, bus.SrcA, bus.SrcB, bus.illegal); end
        n_vec++; if (bus.issue_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_max: got %h expected ffff", bus.issue_count); end
        @(negedge clk);
        n_vec++; if ({bus.out_valid, bus.issue_count} !== {1'b0, 16'd0}) begin n_err++; $display("FAIL wrap_zero: got %b/%h expected 0/0000", bus.out_valid, bus.issue_count); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.opcode = '0;
        bus.funct3 = '0;
        bus.funct7 = '0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.imm = '0;
        test_reset;
        test_rtype_sub;
        test_back_to_back;
        test_illegal;
        test_flush;
        test_wrap_lui;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
